serial_addsub_w: RTL and testbench

Byte-serial add/subtract sequencer that drives a single `rca_8bit` instance to compute a multi-byte sum or difference. Each cycle it feeds one operand byte to the adder and registers the carry between bytes. For subtraction it feeds the adder `in2 = ~b_byte` with an initial `cin = 1`, giving two's-complement subtraction through the 8-bit ripple-carry adder. It provides a start/busy/done handshake to the control logic upstream and holds the full-width result plus flags for downstream consumers.

---
 rtl/serial_addsub_w.sv | 219 +++++++++++++++++++++
 tb/tb_serial_addsub_w.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_w.sv
// -----------------------------------------------------------------------------
// serial_addsub_w
//   Byte-serial add/subtract sequencer. A single 8-bit ripple-carry adder
//   (rca_8bit) is reused once per byte, least-significant byte first, with the
//   carry registered between bytes. Subtraction feeds ~b with an initial
//   carry-in of 1 (two's complement).
//
//   Optional feature macro: ADDSUB_OVF_EN
//     defined   -> ovf_o port and signed-overflow logic are built
//     undefined -> no ovf_o port, no overflow logic
//
//   Ports
//     clk_i     rising-edge clock
//     rst_i     asynchronous active-high reset
//     start_i   request a new operation (sampled only while busy_o = 0)
//     sub_i     0: a + b, 1: a - b (latched with start_i)
//     a_i, b_i  operands, W = 8*NBYTES bits (latched with start_i)
//     busy_o    bytes are being processed
//     done_o    one-cycle pulse: result_o and flags valid
//     result_o  sum/difference, held until the next accepted start
//     cout_o    carry out of the top byte (subtraction: 1 = no borrow)
//     zero_o    result_o == 0
//     ovf_o     signed overflow (ADDSUB_OVF_EN only)
// -----------------------------------------------------------------------------

// 8-bit ripple-carry adder: the only combinational datapath in the block.
module rca_8bit (
   input  logic [7:0] in1_i,
   input  logic [7:0] in2_i,
   input  logic       cin_i,
   output logic [7:0] sum_o,
   output logic       cout_o
);
   logic [8:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign sum_o[i] = in1_i[i] ^ in2_i[i] ^ c[i];
      assign c[i+1]   = (in1_i[i] & in2_i[i]) | (c[i] & (in1_i[i] ^ in2_i[i]));
   end

   assign cout_o = c[8];
endmodule

module serial_addsub_w #(
   parameter int NBYTES = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                sub_i,
   input  logic [8*NBYTES-1:0] a_i,
   input  logic [8*NBYTES-1:0] b_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [8*NBYTES-1:0] result_o,
   output logic                cout_o,
   output logic                zero_o
`ifdef ADDSUB_OVF_EN
   ,
   output logic                ovf_o
`endif
);
   localparam int            IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [NBYTES-1:0][7:0]   a_q, a_d;
   logic [NBYTES-1:0][7:0]   b_q, b_d;
   logic [NBYTES-1:0][7:0]   result_q, result_d;
   logic                     sub_q, sub_d;
   logic                     carry_q, carry_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     cout_q, cout_d;
   logic                     zero_q, zero_d;
`ifdef ADDSUB_OVF_EN
   logic                     ovf_q, ovf_d;
`endif

   // Adder hookup for the byte currently selected by idx_q.
   logic [7:0] add_in1, add_in2, add_sum;
   logic       add_cout;

   assign add_in1 = a_q[idx_q];
   assign add_in2 = sub_q ? ~b_q[idx_q] : b_q[idx_q];

   rca_8bit u_rca (
      .in1_i  (add_in1),
      .in2_i  (add_in2),
      .cin_i  (carry_q),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
`ifdef ADDSUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         sub_q    <= sub_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cout_q   <= cout_d;
         zero_q   <= zero_d;
`ifdef ADDSUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Next-state / datapath control
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cout_d   = cout_q;
      zero_d   = zero_q;
`ifdef ADDSUB_OVF_EN
      ovf_d    = ovf_q;
`endif

      case (state_q)
         // DONE accepts start exactly like IDLE, which gives back-to-back
         // throughput of one operation per NBYTES+1 cycles.
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               sub_d   = sub_i;
               idx_d   = '0;
               carry_d = sub_i;   // +1 completes the two's complement of b
               busy_d  = 1'b1;
               // Flags describe only a finished result; drop the stale ones.
               cout_d  = 1'b0;
               zero_d  = 1'b0;
`ifdef ADDSUB_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            result_d[idx_q] = add_sum;
            carry_d         = add_cout;
            idx_d           = idx_q + IW'(1);
            if (idx_q == LAST) begin
               idx_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cout_d  = add_cout;
               // result_d already holds the top byte, so this sees the whole word.
               zero_d  = (result_d == '0);
`ifdef ADDSUB_OVF_EN
               // Top byte is on the adder now: operand MSBs agree but the
               // result MSB differs.
               ovf_d   = (a_q[NBYTES-1][7] == add_in2[7]) &&
                         (add_sum[7] != a_q[NBYTES-1][7]);
`endif
               state_d = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;
   assign cout_o   = cout_q;
   assign zero_o   = zero_q;
`ifdef ADDSUB_OVF_EN
   assign ovf_o    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_w.sv
module tb_serial_addsub_w;
   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a, b;
   logic         busy, done, cout, zero;
   logic [W-1:0] result;
`ifdef ADDSUB_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_addsub_w #(.NBYTES(NBYTES)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .sub_i    (sub),
      .a_i      (a),
      .b_i      (b),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result),
      .cout_o   (cout),
      .zero_o   (zero)
`ifdef ADDSUB_OVF_EN
      ,
      .ovf_o    (ovf)
`endif
   );

   // Reference model in plain integer arithmetic: returns {ovf, cout, result}.
   function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x, y);
      logic [W:0]   wide;
      logic [W-1:0] r;
      logic         c, o;
      longint       sx, sy, sr;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (s) begin
         r  = x - y;
         c  = (x >= y);             // no borrow
         sr = sx - sy;
      end else begin
         wide = {1'b0, x} + {1'b0, y};
         r  = wide[W-1:0];
         c  = wide[W];
         sr = sx + sy;
      end
      o = (sr > longint'(2**(W-1) - 1)) || (sr < -longint'(2**(W-1)));
      return {o, c, r};
   endfunction

   // Drives one start pulse; returns the number of edges after the accepting
   // edge until done was seen (-1 if it never came). Leaves time at #1 after
   // the done edge.
   task automatic do_op(input logic s, input logic [W-1:0] x, y, output int lat);
      @(negedge clk);
      start = 1'b1; sub = s; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin lat = i; break; end
      end
   endtask

   task automatic test_reset;
      #1;
      checks++; if ({busy, done, cout, zero} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, cout, zero}); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
`ifdef ADDSUB_OVF_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got %b exp 00", {busy, done}); end
   endtask

   task automatic test_sub_no_borrow;
      @(negedge clk);
      start = 1'b1; sub = 1'b1; a = 15; b = 7;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL sub_E0 busy/done got %b exp 10", {busy, done}); end
      for (int k = 1; k < NBYTES; k++) begin
         @(posedge clk); #1;
         checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL sub_E%0d busy/done got %b exp 10", k, {busy, done}); end
      end
      @(posedge clk); #1;
      checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL sub_done_edge busy/done got %b exp 01", {busy, done}); end
      checks++; if (result !== 32'd8) begin errors++; $display("FAIL sub_result got %h exp 8", result); end
      checks++; if ({cout, zero} !== 2'b10) begin errors++; $display("FAIL sub_cout_zero got %b exp 10", {cout, zero}); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL sub_done_pulse got %b exp 0", done); end
      checks++; if (result !== 32'd8) begin errors++; $display("FAIL sub_result_hold got %h exp 8", result); end
   endtask

   task automatic test_carry;
      int lat;
      do_op(1'b0, 32'h0000_00FF, 32'h1, lat);
      checks++; if (lat !== NBYTES) begin errors++; $display("FAIL carry1_latency got %0d exp %0d", lat, NBYTES); end
      checks++; if (result !== 32'h0000_0100) begin errors++; $display("FAIL carry1_result got %h exp 00000100", result); end
      checks++; if ({cout, zero} !== 2'b00) begin errors++; $display("FAIL carry1_cout_zero got %b exp 00", {cout, zero}); end
      do_op(1'b0, 32'hFFFF_FFFF, 32'h1, lat);
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL carry2_result got %h exp 0", result); end
      checks++; if ({cout, zero} !== 2'b11) begin errors++; $display("FAIL carry2_cout_zero got %b exp 11", {cout, zero}); end
   endtask

   task automatic test_borrow_zero;
      int lat;
      do_op(1'b1, 32'd3, 32'd9, lat);
      checks++; if (result !== 32'hFFFF_FFFA) begin errors++; $display("FAIL borrow_result got %h exp FFFFFFFA", result); end
      checks++; if ({cout, zero} !== 2'b00) begin errors++; $display("FAIL borrow_cout_zero got %b exp 00", {cout, zero}); end
      do_op(1'b1, 32'd5, 32'd5, lat);
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL eqsub_result got %h exp 0", result); end
      checks++; if ({cout, zero} !== 2'b11) begin errors++; $display("FAIL eqsub_cout_zero got %b exp 11", {cout, zero}); end
   endtask

`ifdef ADDSUB_OVF_EN
   task automatic test_ovf;
      int lat;
      do_op(1'b0, 32'h7FFF_FFFF, 32'h1, lat);
      checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL ovf1_result got %h exp 80000000", result); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf1 got %b exp 1", ovf); end
      do_op(1'b1, 32'h8000_0000, 32'h1, lat);
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf2 got %b exp 1", ovf); end
      do_op(1'b0, 32'd6, 32'd3, lat);
      checks++; if ({result, ovf} !== {32'd9, 1'b0}) begin errors++; $display("FAIL ovf3 got %h/%b exp 9/0", result, ovf); end
   endtask
`endif

   task automatic test_start_during_busy;
      int lat, extra;
      @(negedge clk);
      start = 1'b1; sub = 1'b0; a = 100; b = 23;
      @(posedge clk);                      // E0
      @(negedge clk); start = 1'b0;
      @(posedge clk);                      // E1
      @(posedge clk);                      // E2
      @(negedge clk); start = 1'b1; sub = 1'b1; a = 999; b = 1;
      @(posedge clk);                      // E3: must be ignored
      @(negedge clk); start = 1'b0; a = 0; b = 0;
      lat = -1;
      for (int i = 4; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin lat = i; break; end
      end
      checks++; if (lat !== NBYTES) begin errors++; $display("FAIL busy_start_latency got %0d exp %0d", lat, NBYTES); end
      checks++; if (result !== 32'd123) begin errors++; $display("FAIL busy_start_result got %0d exp 123", result); end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_extra_activity got %0d exp 0", extra); end
   endtask

   task automatic test_reset_mid_op;
      int lat;
      @(negedge clk);
      start = 1'b1; sub = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
      @(posedge clk);                      // E0
      @(negedge clk); start = 1'b0;
      @(posedge clk);                      // E1: byte 0 written
      @(negedge clk); rst = 1'b1;          // during second RUN cycle
      #1;
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rstmid_busy_done got %b exp 00", {busy, done}); end
      checks++; if (result !== '0) begin errors++; $display("FAIL rstmid_result got %h exp 0", result); end
      @(negedge clk); rst = 1'b0;
      do_op(1'b0, 32'd6, 32'd3, lat);
      checks++; if (lat !== NBYTES) begin errors++; $display("FAIL rstmid_after_latency got %0d exp %0d", lat, NBYTES); end
      checks++; if (result !== 32'd9) begin errors++; $display("FAIL rstmid_after_result got %0d exp 9", result); end
   endtask

   task automatic test_random;
      int lat;
      logic s;
      logic [W-1:0] x, y;
      logic [W+1:0] e;
      for (int n = 0; n < 24; n++) begin
         s = 1'($urandom);
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 3))
            0: y = x;                          // difference of zero
            1: x = {1'b0, {(W-1){1'b1}}};      // max positive
            default: ;
         endcase
         e = model(s, x, y);
         do_op(s, x, y, lat);
         checks++; if (lat !== NBYTES) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", n, lat, NBYTES); end
         checks++; if (result !== e[W-1:0]) begin errors++; $display("FAIL rand%0d_result sub=%b a=%h b=%h got %h exp %h", n, s, x, y, result, e[W-1:0]); end
         checks++; if ({cout, zero} !== {e[W], e[W-1:0] == '0}) begin errors++; $display("FAIL rand%0d_cout_zero got %b exp %b", n, {cout, zero}, {e[W], e[W-1:0] == '0}); end
`ifdef ADDSUB_OVF_EN
         checks++; if (ovf !== e[W+1]) begin errors++; $display("FAIL rand%0d_ovf got %b exp %b", n, ovf, e[W+1]); end
`endif
      end
   endtask

   task automatic test_back_to_back;
      logic [W+1:0] q[$];
      logic [W+1:0] e;
      logic s;
      logic [W-1:0] x, y;
      int issued, got, cyc, last;
      @(negedge clk);
      s = 1'($urandom); x = $urandom; y = $urandom;
      start = 1'b1; sub = s; a = x; b = y;
      q.push_back(model(s, x, y));
      issued = 1; got = 0; cyc = 0; last = -1;
      for (int c = 0; c < 200 && got < 6; c++) begin
         @(posedge clk); #1;
         cyc++;
         if (done === 1'b1) begin
            e = q.pop_front();
            checks++; if (result !== e[W-1:0]) begin errors++; $display("FAIL b2b%0d_result got %h exp %h", got, result, e[W-1:0]); end
            if (last >= 0) begin
               checks++; if (cyc - last !== NBYTES + 1) begin errors++; $display("FAIL b2b%0d_interval got %0d exp %0d", got, cyc - last, NBYTES + 1); end
            end
            last = cyc;
            got++;
            if (issued < 6) begin
               s = 1'($urandom); x = $urandom; y = $urandom;
               sub = s; a = x; b = y;
               q.push_back(model(s, x, y));
               issued++;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      checks++; if (got !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      test_reset;
      test_sub_no_borrow;
      test_carry;
      test_borrow_zero;
`ifdef ADDSUB_OVF_EN
      test_ovf;
`endif
      test_start_during_busy;
      test_reset_mid_op;
      test_random;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
